dec_out_buf: RTL

- Output-side buffer of the iterative decoding chain; the counterpart to the input codeword RAM that replays each frame ITER times into the decoder.
- Collects the decoder's per-iteration output stream of DEPTH symbols per pass, ITER passes per frame.
- Retains only the final-iteration result, then drains it to downstream logic with a valid/ready handshake.
- Flags and drops input that arrives while a drain is in progress.

---
 rtl/dec_out_buf.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/dec_out_buf.sv
// dec_out_buf: output-side frame buffer of the iterative decoder.
//
// Collects DEPTH symbols per decoder pass for ITER passes per frame. Each pass
// overwrites the previous one, so only the final-iteration result is kept. That
// result is then drained from address 0 to DEPTH-1 over a valid/ready interface.
// Input that arrives during a drain is discarded and raises the sticky ovf flag.
//
// Ports:
//   clk      working clock
//   rst      synchronous, active-high reset
//   di       decoded symbol from the decoder
//   di_vld   di valid, one symbol per cycle, no back-pressure
//   do_data  buffered symbol to downstream ("do" is a reserved word)
//   do_vld   do_data valid
//   do_rdy   downstream ready; a beat transfers on do_vld && do_rdy
//   do_last  marks the final beat (index DEPTH-1) of a drain
//   busy     high while draining
//   ovf      sticky overflow flag, cleared only by rst
//   do_iter  pass index of the drained data (DOB_ALL_ITER_EN builds only)
//
// Optional feature, macro DOB_ALL_ITER_EN: every completed pass is drained, not
// only the last one, and do_iter reports which pass is being drained.
//
// Read path: a synchronous read port feeds a read-stage register, which feeds
// the output register. The read stage doubles as a prefetch slot, so beats can
// go out every cycle while do_rdy stays high, and do_vld rises two cycles after
// the final input symbol is accepted.

module dec_out_buf #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned DW    = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned ITER  = 4,
  localparam int unsigned IW   = (ITER > 1) ? $clog2(ITER) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] di,
  input  logic          di_vld,
  output logic [DW-1:0] do_data,
  output logic          do_vld,
  input  logic          do_rdy,
  output logic          do_last,
  output logic          busy,
  output logic          ovf
`ifdef DOB_ALL_ITER_EN
  ,
  output logic [IW-1:0] do_iter
`endif
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [IW-1:0] LastIter = IW'(ITER - 1);

  typedef enum logic [0:0] {
    StCollect,
    StDrain
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [IW-1:0] iter_cnt_q, iter_cnt_d;
  logic [AW-1:0] ra_q, ra_d;            // next read address to issue
  logic          ra_done_q, ra_done_d;  // all DEPTH reads of this drain issued
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;    // index of the beat currently on the output
  logic          rd_vld_q, rd_vld_d;    // read stage holds a fetched symbol
  logic          rd_last_q, rd_last_d;  // that symbol is index DEPTH-1
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] do_q, do_d;
  logic          do_vld_q, do_vld_d;
  logic          do_last_q, do_last_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;

  logic [DW-1:0] mem [DEPTH];

  logic wr_en;
  logic out_take;  // output register can load this cycle
  logic do_hs;
  logic rd_en;

  always_comb begin
    wr_en    = (state_q == StCollect) && di_vld;
    do_hs    = do_vld_q && do_rdy;
    out_take = !do_vld_q || do_rdy;
    // Issue a read only if the read stage is empty or is being emptied now.
    rd_en    = (state_q == StDrain) && !ra_done_q && (!rd_vld_q || out_take);
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    iter_cnt_d = iter_cnt_q;
    ra_d       = ra_q;
    ra_done_d  = ra_done_q;
    rd_cnt_d   = rd_cnt_q;
    rd_vld_d   = rd_vld_q;
    rd_last_d  = rd_last_q;
    do_d       = do_q;
    do_vld_d   = do_vld_q;
    do_last_d  = do_last_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StCollect: begin
        if (di_vld) begin
          if (wr_cnt_q == LastAddr) begin
            wr_cnt_d = '0;
`ifdef DOB_ALL_ITER_EN
            // Every pass is drained; iter_cnt advances when the drain ends.
            state_d = StDrain;
            busy_d  = 1'b1;
`else
            if (iter_cnt_q == LastIter) begin
              iter_cnt_d = '0;
              state_d    = StDrain;
              busy_d     = 1'b1;
            end else begin
              iter_cnt_d = iter_cnt_q + 1'b1;
            end
`endif
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end

      StDrain: begin
        // Includes the cycle of the final handshake: that symbol is dropped too.
        if (di_vld) begin
          ovf_d = 1'b1;
        end

        if (rd_en) begin
          rd_vld_d  = 1'b1;
          rd_last_d = (ra_q == LastAddr);
          if (ra_q == LastAddr) begin
            ra_d      = '0;
            ra_done_d = 1'b1;
          end else begin
            ra_d = ra_q + 1'b1;
          end
        end else if (out_take) begin
          rd_vld_d = 1'b0;
        end

        if (rd_vld_q && out_take) begin
          do_d      = rd_data_q;
          do_vld_d  = 1'b1;
          do_last_d = rd_last_q;
        end else if (do_hs) begin
          do_vld_d  = 1'b0;
          do_last_d = 1'b0;
        end

        if (do_hs) begin
          if (rd_cnt_q == LastAddr) begin
            rd_cnt_d  = '0;
            ra_done_d = 1'b0;
            state_d   = StCollect;
            busy_d    = 1'b0;
`ifdef DOB_ALL_ITER_EN
            iter_cnt_d = (iter_cnt_q == LastIter) ? '0 : iter_cnt_q + 1'b1;
`endif
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCollect;
      wr_cnt_q   <= '0;
      iter_cnt_q <= '0;
      ra_q       <= '0;
      ra_done_q  <= 1'b0;
      rd_cnt_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      do_q       <= '0;
      do_vld_q   <= 1'b0;
      do_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      iter_cnt_q <= iter_cnt_d;
      ra_q       <= ra_d;
      ra_done_q  <= ra_done_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      do_q       <= do_d;
      do_vld_q   <= do_vld_d;
      do_last_q  <= do_last_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset; contents are only read after a full frame is written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_cnt_q] <= di;
    end
    if (rd_en) begin
      rd_data_q <= mem[ra_q];
    end
  end

  assign do_data = do_q;
  assign do_vld  = do_vld_q;
  assign do_last = do_last_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;
`ifdef DOB_ALL_ITER_EN
  assign do_iter = iter_cnt_q;
`endif

endmodule
